// File: rtl/tff_down_timer.sv
// Down-counting timer built from T flip-flops, with a reload register and an
// IDLE/RUN/DONE control FSM. It supports one-shot and periodic (auto-reload) modes.
module tff_down_timer #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Clr_,
    input  logic         ClrS_,
    input  logic         Load,
    input  logic [N-1:0] DD,
    input  logic         Start,
    input  logic         En,
    input  logic         Reload,
    output logic [N-1:0] QQ,
    output logic         TCO,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] rr;
    logic [N-1:0] rr_next;
    logic [N-1:0] qq_next;
    logic [N-1:0] tog;
    logic         done_next;
    logic         count;
    logic         qq_zero;
    logic         qq_one;
    logic         low_zero;

    assign qq_zero = (QQ == '0);
    assign qq_one  = (QQ == N'(1));
    assign TCO     = qq_zero;
    assign Busy    = (state == RUN);

    // T flip-flop toggle enables: a bit toggles when every lower bit is zero.
    // The count is gated at zero, so the counter never wraps.
    always_comb begin
        count    = (state == RUN) && En && !qq_zero;
        tog      = '0;
        low_zero = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            tog[i]   = count && low_zero;
            low_zero = low_zero && !QQ[i];
        end
    end

    // Next state, count, reload register and expiry pulse.
    // Priority is ClrS_ > Load > Start > En. A Start in RUN is ignored and falls through to En.
    always_comb begin
        qq_next    = QQ;
        rr_next    = rr;
        state_next = state;
        done_next  = 1'b0;
        if (!ClrS_) begin
            qq_next    = '0;
            rr_next    = '0;
            state_next = IDLE;
        end else if (Load) begin
            qq_next    = DD;
            rr_next    = DD;
            state_next = IDLE;
        end else if (Start && (state != RUN)) begin
            case (state)
                IDLE: begin
                    if (!qq_zero) begin
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
                DONE: begin
                    qq_next = rr;
                    if (rr != '0) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (count) begin
            if (qq_one) begin
                done_next = 1'b1;
                if (Reload) begin
                    qq_next = rr;
                end else begin
                    qq_next    = QQ ^ tog;
                    state_next = DONE;
                end
            end else begin
                qq_next = QQ ^ tog;
            end
        end
    end

    // State, count, reload and Done registers. Clr_ clears them asynchronously.
    always_ff @(posedge Clk or negedge Clr_) begin
        if (!Clr_) begin
            state <= IDLE;
            QQ    <= '0;
            rr    <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            QQ    <= qq_next;
            rr    <= rr_next;
            Done  <= done_next;
        end
    end

endmodule

// File: tb/tb_tff_down_timer.sv
// Testbench for tff_down_timer. It runs directed scenarios and randomized
// traffic against a behavioural model.
module tb_tff_down_timer;

    logic       Clk = 1'b0;
    logic       Clr_;
    logic       ClrS_;
    logic       Load;
    logic [3:0] DD;
    logic       Start;
    logic       En;
    logic       Reload;
    logic [3:0] QQ;
    logic       TCO;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a count, a reload value, a mode, and a pulse flag.
    logic [3:0] m_q;
    logic [3:0] m_r;
    int         m_mode;   // 0 waiting, 1 counting, 2 expired
    logic       m_done;

    tff_down_timer #(.N(4)) dut (
        .Clk    (Clk),
        .Clr_   (Clr_),
        .ClrS_  (ClrS_),
        .Load   (Load),
        .DD     (DD),
        .Start  (Start),
        .En     (En),
        .Reload (Reload),
        .QQ     (QQ),
        .TCO    (TCO),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_q    = 4'd0;
        m_r    = 4'd0;
        m_mode = 0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (!Clr_) begin
            model_reset();
            return;
        end
        if (!ClrS_) begin
            m_q = 0; m_r = 0; m_mode = 0;
        end else if (Load) begin
            m_q = DD; m_r = DD; m_mode = 0;
        end else if (Start && m_mode == 0) begin
            if (m_q != 0) m_mode = 1;
            else begin m_mode = 2; nd = 1'b1; end
        end else if (Start && m_mode == 2) begin
            m_q = m_r;
            if (m_r != 0) m_mode = 1;
            else nd = 1'b1;
        end else if (En && m_mode == 1) begin
            if (m_q > 1) m_q = m_q - 4'd1;
            else if (m_q == 1) begin
                nd = 1'b1;
                if (Reload) m_q = m_r;
                else begin m_q = 0; m_mode = 2; end
            end
        end
        m_done = nd;
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic drive(input logic ld, input logic [3:0] dd, input logic st,
                         input logic en, input logic rl, input logic clrs);
        Load = ld; DD = dd; Start = st; En = en; Reload = rl; ClrS_ = clrs;
    endtask

    task automatic test_reset();
        Clr_ = 1'b0;
        drive(0, 4'd0, 0, 0, 0, 1);
        model_reset();
        #1;
        checks++; if (QQ !== 4'd0) begin errors++; $display("FAIL reset_qq: got %0d expected 0", QQ); end
        checks++; if (TCO !== 1'b1) begin errors++; $display("FAIL reset_tco: got %b expected 1", TCO); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
        // Synchronous inputs are ignored while Clr_ is held low.
        @(negedge Clk);
        drive(1, 4'd7, 1, 1, 0, 1);
        cycle();
        checks++; if (QQ !== 4'd0) begin errors++; $display("FAIL reset_hold_qq: got %0d expected 0", QQ); end
        Clr_ = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 1);
        cycle();
    endtask

    task automatic test_oneshot();
        drive(1, 4'd3, 0, 0, 0, 1); cycle();
        checks++; if (QQ !== 4'd3 || Busy !== 1'b0) begin errors++; $display("FAIL oneshot_load: qq %0d busy %b expected 3 0", QQ, Busy); end
        drive(0, 4'd0, 1, 1, 0, 1); cycle();
        checks++; if (QQ !== 4'd3 || Busy !== 1'b1) begin errors++; $display("FAIL oneshot_start: qq %0d busy %b expected 3 1", QQ, Busy); end
        drive(0, 4'd0, 0, 1, 0, 1);
        for (int k = 2; k >= 0; k--) begin
            cycle();
            checks++; if (QQ !== 4'(k)) begin errors++; $display("FAIL oneshot_count: got %0d expected %0d", QQ, k); end
        end
        checks++; if (Done !== 1'b1 || Busy !== 1'b0 || TCO !== 1'b1) begin
            errors++; $display("FAIL oneshot_expire: done %b busy %b tco %b expected 1 0 1", Done, Busy, TCO); end
        cycle();
        checks++; if (Done !== 1'b0 || QQ !== 4'd0) begin errors++; $display("FAIL oneshot_after: done %b qq %0d expected 0 0", Done, QQ); end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_periodic();
        logic [3:0] eq [5] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        logic       ed [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        drive(1, 4'd2, 0, 0, 1, 1); cycle();
        drive(0, 4'd0, 1, 1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            drive(0, 4'd0, 0, 1, 1, 1);
            checks++; if (QQ !== eq[k] || Done !== ed[k] || Busy !== 1'b1) begin
                errors++; $display("FAIL periodic_step%0d: qq %0d done %b busy %b expected %0d %b 1", k, QQ, Done, Busy, eq[k], ed[k]); end
        end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_en_gating();
        logic [3:0] eq [6] = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2};
        drive(1, 4'd5, 0, 0, 0, 1); cycle();
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        for (int k = 0; k < 6; k++) begin
            drive(0, 4'd0, (k == 1 || k == 2), (k % 2 == 0), 0, 1);
            cycle();
            checks++; if (QQ !== eq[k] || Busy !== 1'b1) begin
                errors++; $display("FAIL en_gating_step%0d: qq %0d busy %b expected %0d 1", k, QQ, Busy, eq[k]); end
        end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_priority();
        drive(1, 4'd6, 0, 0, 0, 1); cycle();
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        drive(0, 4'd0, 0, 1, 0, 1); cycle(); cycle();
        checks++; if (QQ !== 4'd4) begin errors++; $display("FAIL prio_setup: got %0d expected 4", QQ); end
        drive(1, 4'd9, 0, 1, 0, 1); cycle();
        checks++; if (QQ !== 4'd9 || Busy !== 1'b0) begin errors++; $display("FAIL prio_load: qq %0d busy %b expected 9 0", QQ, Busy); end
        drive(0, 4'd0, 1, 0, 0, 0); cycle();
        checks++; if (QQ !== 4'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL prio_clrs: qq %0d busy %b done %b expected 0 0 0", QQ, Busy, Done); end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_zero_and_async();
        drive(1, 4'd0, 0, 0, 0, 1); cycle();
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        checks++; if (Done !== 1'b1 || QQ !== 4'd0 || Busy !== 1'b0) begin
            errors++; $display("FAIL zero_start: done %b qq %0d busy %b expected 1 0 0", Done, QQ, Busy); end
        drive(0, 4'd0, 0, 0, 0, 1); cycle();
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL zero_pulse_len: got %b expected 0", Done); end
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL zero_restart: done %b busy %b expected 1 0", Done, Busy); end
        drive(1, 4'd7, 0, 0, 0, 1); cycle();
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        drive(0, 4'd0, 0, 1, 0, 1); cycle(); cycle();
        checks++; if (QQ !== 4'd5 || Busy !== 1'b1) begin errors++; $display("FAIL async_setup: qq %0d busy %b expected 5 1", QQ, Busy); end
        #2 Clr_ = 1'b0;
        model_reset();
        #1;
        checks++; if (QQ !== 4'd0 || Busy !== 1'b0 || Done !== 1'b0 || TCO !== 1'b1) begin
            errors++; $display("FAIL async_clear: qq %0d busy %b done %b tco %b expected 0 0 0 1", QQ, Busy, Done, TCO); end
        @(negedge Clk);
        Clr_ = 1'b1;
        drive(1, 4'd3, 0, 0, 0, 1); cycle();
        checks++; if (QQ !== 4'd3 || Done !== 1'b0) begin errors++; $display("FAIL async_resume: qq %0d done %b expected 3 0", QQ, Done); end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_full_range();
        int ticks;
        ticks = 0;
        drive(1, 4'd15, 0, 0, 0, 1); cycle();
        drive(0, 4'd0, 1, 0, 0, 1); cycle();
        drive(0, 4'd0, 0, 1, 0, 1);
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (Done === 1'b1) begin ticks = k; break; end
        end
        checks++; if (ticks != 15) begin errors++; $display("FAIL full_range_ticks: got %0d expected 15 (0 means timeout)", ticks); end
        for (int k = 0; k < 5; k++) cycle();
        checks++; if (QQ !== 4'd0 || Busy !== 1'b0) begin errors++; $display("FAIL full_range_nowrap: qq %0d busy %b expected 0 0", QQ, Busy); end
        drive(0, 4'd0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(15) == 0), 4'($urandom_range(15)), ($urandom_range(5) == 0),
                  ($urandom_range(2) != 0), 1'($urandom_range(1)), ($urandom_range(40) != 0));
            if ($urandom_range(60) == 0) begin
                #2 Clr_ = 1'b0;
                model_reset();
                #1;
                checks++; if (QQ !== 4'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
                    errors++; $display("FAIL random_async%0d: qq %0d busy %b done %b expected 0 0 0", k, QQ, Busy, Done); end
                cycle();
                Clr_ = 1'b1;
            end else begin
                cycle();
            end
            checks++;
            if (QQ !== m_q || Done !== m_done || Busy !== (m_mode == 1) || TCO !== (m_q == 4'd0)) begin
                errors++;
                $display("FAIL random%0d: qq %0d done %b busy %b tco %b expected %0d %b %b %b",
                         k, QQ, Done, Busy, TCO, m_q, m_done, (m_mode == 1), (m_q == 4'd0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_en_gating();
        test_priority();
        test_zero_and_async();
        test_full_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
